// File: rtl/lbist_pkg.sv
// Shared types, default constants and the Galois LFSR step used by the logic-BIST controller.
package lbist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SHIFT,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_COMPARE,
    ST_DONE
  } lbist_state_e;

  localparam int unsigned DEF_LFSR_W = 32;
  localparam logic [DEF_LFSR_W-1:0] DEF_SEED = 32'h0000_0001;
  localparam logic [DEF_LFSR_W-1:0] DEF_POLY = 32'h8020_0003;

  // Widest register the step function supports; callers zero-extend and truncate.
  localparam int unsigned LFSR_MAX_W = 64;
  typedef logic [LFSR_MAX_W-1:0] lfsr_word_t;

  function automatic lfsr_word_t lfsr_next(input lfsr_word_t r, input lfsr_word_t poly,
                                           input int unsigned w);
    lfsr_word_t shifted;
    logic       msb;
    shifted = r << 1;
    msb     = |(r & (lfsr_word_t'(1) << (w - 1)));
    return shifted ^ (msb ? poly : '0);
  endfunction

endpackage

// File: rtl/lbist_lfsr.sv
// Galois LFSR with synchronous load and an XOR data input, used both as PRPG and as MISR.
module lbist_lfsr
  import lbist_pkg::*;
#(
  parameter int unsigned     W        = DEF_LFSR_W,
  parameter int unsigned     OUT_W    = W,
  parameter logic [W-1:0]    POLY     = DEF_POLY[W-1:0],
  parameter logic [W-1:0]    LOAD_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [W-1:0]     data_i,
  output logic [OUT_W-1:0] state_o
);

  logic [W-1:0] state_q, state_d;

  // NOTE: every path assigns state_d because the hold value comes first; no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = LOAD_VAL;
    end else if (en_i) begin
      state_d = W'(lfsr_next(LFSR_MAX_W'(state_q), LFSR_MAX_W'(POLY), W)) ^ data_i;
    end
  end

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LOAD_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/lbist_controller.sv
// Logic-BIST sequencer: PRPG drives scan chains, MISR compacts unloads, signature compared at the end.
module lbist_controller
  import lbist_pkg::*;
#(
  parameter int unsigned         N_CHAINS   = 4,
  parameter int unsigned         CHAIN_LEN  = 64,
  parameter int unsigned         N_PATTERNS = 1024,
  parameter int unsigned         LFSR_W     = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0]   PRPG_SEED  = DEF_SEED[LFSR_W-1:0],
  parameter logic [LFSR_W-1:0]   PRPG_POLY  = DEF_POLY[LFSR_W-1:0],
  parameter logic [LFSR_W-1:0]   MISR_POLY  = DEF_POLY[LFSR_W-1:0],
  parameter logic [LFSR_W-1:0]   GOLDEN_SIG = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                test_mode_i,
  input  logic                normal_test_i,
  output logic                scan_en_o,
  output logic [N_CHAINS-1:0] scan_in_o,
  input  logic [N_CHAINS-1:0] scan_out_i,
  output logic                busy_o,
  output logic                test_over_o,
  output logic                go_nogo_o
);

  localparam int unsigned SH_W  = $clog2(CHAIN_LEN);
  localparam int unsigned PAT_W = $clog2(N_PATTERNS + 1);

  lbist_state_e      state_q;
  logic [SH_W-1:0]   sh_cnt_q;
  logic [PAT_W-1:0]  pat_cnt_q;
  logic              norm_q;
  logic              scan_en_q, busy_q, test_over_q, go_nogo_q;

  logic                start, shifting, misr_en, sh_last;
  logic [N_CHAINS-1:0] prpg_bits;
  logic [LFSR_W-1:0]   misr;

  assign start    = normal_test_i & ~norm_q & test_mode_i;
  assign shifting = (state_q == ST_SHIFT) || (state_q == ST_UNLOAD);
  assign sh_last  = (sh_cnt_q == SH_W'(CHAIN_LEN - 1));
  // The first pattern's unload carries the unknown power-on chain contents, so it is not compacted.
  assign misr_en  = ((state_q == ST_SHIFT) && (pat_cnt_q != '0)) || (state_q == ST_UNLOAD);

  lbist_lfsr #(
    .W       (LFSR_W),
    .OUT_W   (N_CHAINS),
    .POLY    (PRPG_POLY),
    .LOAD_VAL(PRPG_SEED)
  ) u_prpg (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (state_q == ST_INIT),
    .en_i   (shifting),
    .data_i ('0),
    .state_o(prpg_bits)
  );

  lbist_lfsr #(
    .W       (LFSR_W),
    .OUT_W   (LFSR_W),
    .POLY    (MISR_POLY),
    .LOAD_VAL('0)
  ) u_misr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (state_q == ST_INIT),
    .en_i   (misr_en),
    .data_i (LFSR_W'(scan_out_i)),
    .state_o(misr)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      sh_cnt_q    <= '0;
      pat_cnt_q   <= '0;
      norm_q      <= 1'b0;
      scan_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      test_over_q <= 1'b0;
      go_nogo_q   <= 1'b0;
    end else begin
      norm_q <= normal_test_i;
      if (!test_mode_i && (state_q != ST_IDLE)) begin
        state_q     <= ST_IDLE;
        scan_en_q   <= 1'b0;
        busy_q      <= 1'b0;
        test_over_q <= 1'b0;
        go_nogo_q   <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q <= ST_INIT;
              busy_q  <= 1'b1;
            end
          end
          ST_INIT: begin
            sh_cnt_q    <= '0;
            pat_cnt_q   <= '0;
            test_over_q <= 1'b0;
            go_nogo_q   <= 1'b0;
            scan_en_q   <= 1'b1;
            state_q     <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (sh_last) begin
              scan_en_q <= 1'b0;
              state_q   <= ST_CAPTURE;
            end else begin
              sh_cnt_q <= sh_cnt_q + SH_W'(1);
            end
          end
          ST_CAPTURE: begin
            pat_cnt_q <= pat_cnt_q + PAT_W'(1);
            sh_cnt_q  <= '0;
            scan_en_q <= 1'b1;
            state_q   <= (pat_cnt_q == PAT_W'(N_PATTERNS - 1)) ? ST_UNLOAD : ST_SHIFT;
          end
          ST_UNLOAD: begin
            if (sh_last) begin
              scan_en_q <= 1'b0;
              state_q   <= ST_COMPARE;
            end else begin
              sh_cnt_q <= sh_cnt_q + SH_W'(1);
            end
          end
          ST_COMPARE: begin
            go_nogo_q   <= (misr == GOLDEN_SIG);
            test_over_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_DONE;
          end
          ST_DONE: begin
            if (start) begin
              state_q     <= ST_INIT;
              busy_q      <= 1'b1;
              test_over_q <= 1'b0;
              go_nogo_q   <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign scan_en_o   = scan_en_q;
  assign scan_in_o   = shifting ? prpg_bits : '0;
  assign busy_o      = busy_q;
  assign test_over_o = test_over_q;
  assign go_nogo_o   = go_nogo_q;

endmodule

// File: tb/tb_lbist_controller.sv
// Self-checking bench for lbist_controller with a session-level reference model.
module tb_lbist_controller;

  localparam int         NC     = 2;
  localparam int         CL     = 4;
  localparam int         NP     = 3;
  localparam logic [7:0] SEED   = 8'h01;
  localparam logic [7:0] POLY   = 8'h1D;
  localparam int         DONE_C = 2 + NP * (CL + 1) + CL;
  localparam int         FLIP_C = 1 + 2 * (CL + 1) + 3;

  function automatic logic [7:0] step(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? POLY : 8'h00);
  endfunction

  // Signature of a session whose chains simply delay scan_in by CL shifts, starting empty.
  function automatic logic [7:0] loop_sig();
    logic [7:0]      prpg, misr;
    logic [3:0][1:0] pipe;
    logic [1:0]      out;
    prpg = SEED;
    misr = 8'h00;
    pipe = '0;
    for (int k = 0; k < (NP + 1) * CL; k++) begin
      out = pipe[2'(k % CL)];
      if (k >= CL) misr = step(misr) ^ {6'b0, out};
      pipe[2'(k % CL)] = prpg[1:0];
      prpg = step(prpg);
    end
    return misr;
  endfunction

  localparam logic [7:0] GOLDEN = loop_sig();

  // Cycle c is the interval after the c-th edge following the start edge.
  function automatic bit is_shift(input int c);
    int u;
    if (c < 1) return 1'b0;
    u = c - 1;
    if (u < NP * (CL + 1)) return (u % (CL + 1)) != CL;
    return u < NP * (CL + 1) + CL;
  endfunction

  logic          clk = 1'b0;
  logic          rst_n;
  logic          test_mode_i, normal_test_i;
  logic          scan_en_o, busy_o, test_over_o, go_nogo_o;
  logic [NC-1:0] scan_in_o, scan_out_i;
  int            n_checks = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  lbist_controller #(
    .N_CHAINS  (NC),
    .CHAIN_LEN (CL),
    .N_PATTERNS(NP),
    .LFSR_W    (8),
    .PRPG_SEED (SEED),
    .PRPG_POLY (POLY),
    .MISR_POLY (POLY),
    .GOLDEN_SIG(GOLDEN)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .test_mode_i  (test_mode_i),
    .normal_test_i(normal_test_i),
    .scan_en_o    (scan_en_o),
    .scan_in_o    (scan_in_o),
    .scan_out_i   (scan_out_i),
    .busy_o       (busy_o),
    .test_over_o  (test_over_o),
    .go_nogo_o    (go_nogo_o)
  );

  // mode 0: random chain data, 1: loopback, 2: loopback with one flipped bit.
  task automatic run_session(input string tag, input int mode, input int hold, input int pulse_c,
                             input int abort_c, input int reset_c, input int last_c);
    logic [7:0] prpg_m = SEED;
    logic [7:0] misr_m = 8'h00;
    logic [1:0] pipe_q[$];
    logic [1:0] so = 2'b00;
    logic [4:0] exp_v, obs_v;
    logic       exp_go;
    bit         aborted;
    int         k = 0;
    pipe_q = '{2'b00, 2'b00, 2'b00, 2'b00};
    @(posedge clk);
    #1;
    test_mode_i   = 1'b1;
    normal_test_i = 1'b1;
    scan_out_i    = '0;
    for (int c = 0; c <= last_c; c++) begin
      @(posedge clk);
      if (is_shift(c - 1)) begin
        if (k >= CL) misr_m = step(misr_m) ^ {6'b0, so};
        pipe_q.push_back(prpg_m[1:0]);
        void'(pipe_q.pop_front());
        prpg_m = step(prpg_m);
        k++;
      end
      #1;
      normal_test_i = (c <= hold - 2) || (c == pulse_c);
      test_mode_i   = !(abort_c >= 0 && c >= abort_c);
      so = 2'b00;
      if (is_shift(c)) begin
        so = (mode == 0) ? 2'($urandom) : pipe_q[0];
        if (mode == 2 && c == FLIP_C) so[0] = ~so[0];
      end
      scan_out_i = so;
      if (c == reset_c) begin
        #2 rst_n = 1'b0;
        #1;
        obs_v = {scan_en_o, scan_in_o, busy_o, test_over_o};
        n_checks++;
        if ({obs_v, go_nogo_o} !== 6'b0)
          $display("FAIL %s async_reset c=%0d got %b want 000000", tag, c, {obs_v, go_nogo_o});
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        scan_out_i = '0;
        return;
      end
      @(negedge clk);
      aborted = (abort_c >= 0) && (c > abort_c);
      exp_v = aborted ? 5'b0 : {is_shift(c), is_shift(c) ? prpg_m[1:0] : 2'b00,
                                c < DONE_C, c >= DONE_C};
      obs_v = {scan_en_o, scan_in_o, busy_o, test_over_o};
      n_checks++;
      if (obs_v !== exp_v)
        $display("FAIL %s outputs c=%0d got en,in,busy,over=%b want %b", tag, c, obs_v, exp_v);
      else n_pass++;
      if (!aborted && c >= DONE_C) begin
        exp_go = (misr_m == GOLDEN);
        n_checks++;
        if (go_nogo_o !== exp_go)
          $display("FAIL %s go_nogo c=%0d got %b want %b", tag, c, go_nogo_o, exp_go);
        else n_pass++;
      end
    end
    normal_test_i = 1'b0;
    scan_out_i    = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    test_mode_i = 1'b0;
    normal_test_i = 1'b0;
    scan_out_i = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({scan_en_o, scan_in_o, busy_o, test_over_o, go_nogo_o} !== 6'b0)
      $display("FAIL reset_values got %b want 000000",
               {scan_en_o, scan_in_o, busy_o, test_over_o, go_nogo_o});
    else n_pass++;
    rst_n = 1'b1;
    test_mode_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({scan_en_o, busy_o, test_over_o} !== 3'b0)
      $display("FAIL idle_after_reset got %b want 000", {scan_en_o, busy_o, test_over_o});
    else n_pass++;
  endtask

  task automatic test_random_session();
    run_session("random", 0, 1, -1, -1, -1, DONE_C + 1);
  endtask

  task automatic test_loopback_pass();
    run_session("loop_pass", 1, 1, -1, -1, -1, DONE_C + 2);
    n_checks++;
    if ({test_over_o, go_nogo_o} !== 2'b11)
      $display("FAIL loop_pass_result got over,go=%b want 11", {test_over_o, go_nogo_o});
    else n_pass++;
  endtask

  task automatic test_loopback_flip();
    run_session("loop_flip", 2, 1, -1, -1, -1, DONE_C + 1);
    n_checks++;
    if ({test_over_o, go_nogo_o} !== 2'b10)
      $display("FAIL loop_flip_result got over,go=%b want 10", {test_over_o, go_nogo_o});
    else n_pass++;
  endtask

  task automatic test_abort();
    run_session("abort", 0, 1, -1, 1 + 1 * (CL + 1) + CL, -1, 13);
    @(posedge clk);
    #1;
    normal_test_i = 1'b1;
    test_mode_i   = 1'b0;
    @(posedge clk);
    #1;
    normal_test_i = 1'b0;
    test_mode_i   = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({scan_en_o, busy_o} !== 2'b00)
      $display("FAIL start_with_mode_low got en,busy=%b want 00", {scan_en_o, busy_o});
    else n_pass++;
  endtask

  task automatic test_held_start();
    run_session("held", 1, 10, 12, -1, -1, DONE_C + 2);
    run_session("restart", 0, 1, -1, -1, -1, DONE_C);
  endtask

  task automatic test_reset_unload();
    run_session("rst_unload", 0, 1, -1, -1, 1 + NP * (CL + 1) + 1, DONE_C);
    run_session("after_rst", 1, 1, -1, -1, -1, DONE_C);
  endtask

  initial begin
    test_reset();
    test_random_session();
    test_loopback_pass();
    test_loopback_flip();
    test_abort();
    test_held_start();
    test_reset_unload();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
